input_debouncer: RTL and testbench
==================================

# input_debouncer

Conditions one raw, asynchronous board input (e.g. a front-panel or connector control line) into a clean, glitch-free level. This level drives the `LONG_SIGNAL` input of the downstream rising-edge detector. The block synchronizes the input into the `CLOCK` domain and accepts a new level only after it has been stable for a programmable number of cycles. It also keeps a saturating count of rejected glitches for diagnostics.

## Interface
- `SYNC_STAGES`, default 2: number of synchronizer flops; legal range 2–4.
- `STABLE_CYCLES`, default 1000: consecutive cycles the synchronized input must differ from the output before the output follows; must be ≥ 2.
- `CNT_WIDTH`, default `clog2(STABLE_CYCLES)`: width of the stability counter; derived, not overridden.
- `GLITCH_WIDTH`, default 8: width of the glitch counter.
- `INIT_LEVEL`, default 1'b0: reset value of the synchronizer flops and of `DEBOUNCED`.

Ports (name, direction, width, meaning):
- `CLOCK` — input — 1 — sole clock; all logic on its rising edge.
- `RESET` — input — 1 — synchronous, active-high reset.
- `RAW_INPUT` — input — 1 — asynchronous raw level.
- `GLITCH_CLEAR` — input — 1 — synchronous clear of `GLITCH_COUNT`.
- `DEBOUNCED` — output — 1 — clean level, registered; feeds the edge detector's `LONG_SIGNAL`.
- `GLITCH_COUNT` — output — `GLITCH_WIDTH` — number of aborted transitions, saturating.

## Operation
- `RAW_INPUT` passes through a `SYNC_STAGES`-deep flop chain; the last stage is `sync_level`. No other logic touches `RAW_INPUT`.
- FSM states:
  - `STABLE`: `sync_level == DEBOUNCED`; the counter is held at 0.
  - `CHECK`: `sync_level != DEBOUNCED`; the counter increments every cycle.
- `STABLE` → `CHECK`: when `sync_level != DEBOUNCED`. The counter is loaded with 1 on that edge.
- `CHECK` → `STABLE` with commit: when the counter equals `STABLE_CYCLES-1` and `sync_level` still differs. On that edge:
  - `DEBOUNCED` inverts;
  - the counter clears.
- `CHECK` → `STABLE` with abort: when `sync_level == DEBOUNCED` before commit. On that edge:
  - the counter clears;
  - `GLITCH_COUNT` increments.
- `GLITCH_COUNT` saturates at all-ones and never wraps.
- `GLITCH_CLEAR` zeroes `GLITCH_COUNT` on the next edge. If it coincides with an abort, clear wins and the result is 0.
- Counter arithmetic is unsigned `CNT_WIDTH`. The counter never exceeds `STABLE_CYCLES-1`, so no wrap is possible.
- Reset values: sync chain = `INIT_LEVEL`, `DEBOUNCED` = `INIT_LEVEL`, counter = 0, state = `STABLE`, `GLITCH_COUNT` = 0.
- Reset has priority over every other event, including reset asserted mid-`CHECK`: the pending transition is discarded and no glitch is counted.

## Timing
- Synchronizer latency: a `RAW_INPUT` change captured at edge k appears on `sync_level` after edge k+`SYNC_STAGES`-1.
- Commit latency: `DEBOUNCED` changes `STABLE_CYCLES` edges after `sync_level` first differs. Total from capture edge to `DEBOUNCED` = `SYNC_STAGES` + `STABLE_CYCLES` - 1 edges.
- A pulse shorter than `STABLE_CYCLES` cycles (as seen on `sync_level`) never reaches `DEBOUNCED` and adds exactly 1 to `GLITCH_COUNT`.
- `DEBOUNCED` changes at most once per `STABLE_CYCLES` cycles, so the downstream detector gets at most one rising pulse per accepted low→high commit.
- `GLITCH_COUNT` updates on the same edge as the abort transition.

## Structure
- Shared package/header `ats3_pkg`:
  - FSM state encoding constants (`ST_STABLE`, `ST_CHECK`);
  - `clog2` function used for `CNT_WIDTH`.
- One sub-module, `sync_chain`: parameterized `SYNC_STAGES`-deep flop chain with `INIT_LEVEL` reset. It is reused for other asynchronous board inputs.
- Everything else (FSM, stability counter, glitch counter) lives in `input_debouncer`.

## Test plan
All scenarios use `SYNC_STAGES`=2, `STABLE_CYCLES`=4, `GLITCH_WIDTH`=3.
- Clean rise: `RAW_INPUT` 0→1 held. `DEBOUNCED` rises exactly 5 edges after the capture edge; `GLITCH_COUNT`=0.
- Glitch: `RAW_INPUT` high for 2 cycles, then low. `DEBOUNCED` stays 0 and `GLITCH_COUNT`=1.
- Borderline pulses:
  - high for 3 cycles → `DEBOUNCED` stays 0, glitch counted;
  - high for 4 cycles → `DEBOUNCED` rises for 4 cycles, then falls after its own debounce.
- Saturation and clear: 9 glitches → `GLITCH_COUNT`=7. `GLITCH_CLEAR` pulsed on the same edge as a 10th abort → `GLITCH_COUNT`=0.
- Mid-operation reset: `RESET` pulsed during `CHECK` with counter=2. All outputs return to reset values next edge and `GLITCH_COUNT` stays 0. With `RAW_INPUT` still 1, `DEBOUNCED` rises 5 edges after reset is released.
- Bounce train: `RAW_INPUT` toggles every cycle for 20 cycles, then holds 1. `DEBOUNCED` rises once, 4 edges after the last toggle reaches `sync_level`. `GLITCH_COUNT` reaches 7, saturated.

Source files
------------

// File: rtl/ats3_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ats3_pkg
// Description : Shared FSM state encoding and constant helpers for the board
//               input conditioning blocks.
// Revision    : 1.0 - initial release
// ============================================================================
package ats3_pkg;

    // Debouncer FSM states, explicit 1-bit encoding
    typedef enum logic [0:0] {
        ST_STABLE = 1'b0,
        ST_CHECK  = 1'b1
    } deb_state_t;

    // Ceiling log2, never less than 1 so derived widths stay legal
    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        if (result < 1) begin
            result = 1;
        end
        return result;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_chain.sv
`default_nettype none
// ============================================================================
// Module      : sync_chain
// Description : SYNC_STAGES-deep flop chain bringing an asynchronous level
//               into the CLOCK domain; reset value is INIT_LEVEL.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_chain #(
    parameter int   SYNC_STAGES = 2,
    parameter logic INIT_LEVEL  = 1'b0
) (
    input  logic CLOCK,
    input  logic RESET,
    input  logic i_async,
    output logic o_sync
);

    logic [SYNC_STAGES-1:0] r_stages;

    // Shift the raw level through the chain; stage 0 is the only one that sees it
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            r_stages <= {SYNC_STAGES{INIT_LEVEL}};
        end else begin
            r_stages <= {r_stages[SYNC_STAGES-2:0], i_async};
        end
    end

    assign o_sync = r_stages[SYNC_STAGES-1];

endmodule
`default_nettype wire

// File: rtl/input_debouncer.sv
`default_nettype none
// ============================================================================
// Module      : input_debouncer
// Description : Synchronizes a raw board input, accepts a new level only after
//               STABLE_CYCLES consecutive differing cycles, and keeps a
//               saturating count of aborted transitions.
// Revision    : 1.0 - initial release
// ============================================================================
module input_debouncer
    import ats3_pkg::*;
#(
    parameter int   SYNC_STAGES   = 2,
    parameter int   STABLE_CYCLES = 1000,
    parameter int   GLITCH_WIDTH  = 8,
    parameter logic INIT_LEVEL    = 1'b0
) (
    input  logic                    CLOCK,
    input  logic                    RESET,
    input  logic                    RAW_INPUT,
    input  logic                    GLITCH_CLEAR,
    output logic                    DEBOUNCED,
    output logic [GLITCH_WIDTH-1:0] GLITCH_COUNT
);

    // Counter only has to reach STABLE_CYCLES-1, so clog2 bits suffice
    localparam int CNT_WIDTH = clog2(STABLE_CYCLES);
    localparam logic [CNT_WIDTH-1:0] c_cnt_last = CNT_WIDTH'(STABLE_CYCLES - 1);

    logic                    w_sync_level;
    deb_state_t              r_state;
    deb_state_t              w_state_nxt;
    logic [CNT_WIDTH-1:0]    r_cnt;
    logic [CNT_WIDTH-1:0]    w_cnt_nxt;
    logic                    r_debounced;
    logic                    w_debounced_nxt;
    logic                    w_abort;
    logic [GLITCH_WIDTH-1:0] r_glitch;

    sync_chain #(
        .SYNC_STAGES (SYNC_STAGES),
        .INIT_LEVEL  (INIT_LEVEL)
    ) u_sync_chain (
        .CLOCK   (CLOCK),
        .RESET   (RESET),
        .i_async (RAW_INPUT),
        .o_sync  (w_sync_level)
    );

    // State, stability counter and output level registers
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            r_state     <= ST_STABLE;
            r_cnt       <= '0;
            r_debounced <= INIT_LEVEL;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_debounced <= w_debounced_nxt;
        end
    end

    // Next-state logic: abort is checked before commit so a level that returns
    // on the final counting cycle still counts as a glitch
    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_debounced_nxt = r_debounced;
        w_abort         = 1'b0;
        case (r_state)
            ST_STABLE: begin
                w_cnt_nxt = '0;
                if (w_sync_level != r_debounced) begin
                    w_state_nxt = ST_CHECK;
                    w_cnt_nxt   = CNT_WIDTH'(1);
                end
            end
            ST_CHECK: begin
                if (w_sync_level == r_debounced) begin
                    w_state_nxt = ST_STABLE;
                    w_cnt_nxt   = '0;
                    w_abort     = 1'b1;
                end else if (r_cnt == c_cnt_last) begin
                    w_state_nxt     = ST_STABLE;
                    w_cnt_nxt       = '0;
                    w_debounced_nxt = ~r_debounced;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_WIDTH'(1);
                end
            end
            default: begin
                w_state_nxt = ST_STABLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Saturating glitch counter; clear beats a coincident abort
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            r_glitch <= '0;
        end else if (GLITCH_CLEAR) begin
            r_glitch <= '0;
        end else if (w_abort && !(&r_glitch)) begin
            r_glitch <= r_glitch + GLITCH_WIDTH'(1);
        end
    end

    assign DEBOUNCED    = r_debounced;
    assign GLITCH_COUNT = r_glitch;

endmodule
`default_nettype wire

// File: tb/tb_input_debouncer.sv
`default_nettype none
// ============================================================================
// Module      : tb_input_debouncer
// Description : Directed self-checking bench for input_debouncer with
//               SYNC_STAGES=2, STABLE_CYCLES=4, GLITCH_WIDTH=3.
//               Edge e of a scenario is the e-th rising edge after stimulus
//               starts; RAW_INPUT set before edge e is captured at edge e.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_input_debouncer;

    logic       CLOCK;
    logic       RESET;
    logic       RAW_INPUT;
    logic       GLITCH_CLEAR;
    logic       DEBOUNCED;
    logic [2:0] GLITCH_COUNT;

    int n_cmp;
    int n_bad;

    input_debouncer #(
        .SYNC_STAGES   (2),
        .STABLE_CYCLES (4),
        .GLITCH_WIDTH  (3),
        .INIT_LEVEL    (1'b0)
    ) dut (
        .CLOCK        (CLOCK),
        .RESET        (RESET),
        .RAW_INPUT    (RAW_INPUT),
        .GLITCH_CLEAR (GLITCH_CLEAR),
        .DEBOUNCED    (DEBOUNCED),
        .GLITCH_COUNT (GLITCH_COUNT)
    );

    initial CLOCK = 1'b0;
    always #5 CLOCK = ~CLOCK;

    // Advance one rising edge and settle
    task automatic step();
        @(posedge CLOCK);
        #1;
    endtask

    task automatic do_reset();
        RESET        = 1'b1;
        RAW_INPUT    = 1'b0;
        GLITCH_CLEAR = 1'b0;
        step();
        step();
        RESET = 1'b0;
    endtask

    task automatic test_reset();
        RESET        = 1'b1;
        RAW_INPUT    = 1'b1;
        GLITCH_CLEAR = 1'b0;
        for (int e = 1; e <= 3; e++) begin
            step();
            n_cmp++;
            if (DEBOUNCED !== 1'b0) begin
                n_bad++;
                $display("FAIL reset_deb edge %0d: got %b want 0", e, DEBOUNCED);
            end
            n_cmp++;
            if (GLITCH_COUNT !== 3'd0) begin
                n_bad++;
                $display("FAIL reset_glitch edge %0d: got %0d want 0", e, GLITCH_COUNT);
            end
        end
        RESET     = 1'b0;
        RAW_INPUT = 1'b0;
    endtask

    // Capture at edge 1 -> sync after edge 2 -> commit at edge 6
    task automatic test_clean_rise();
        logic exp;
        do_reset();
        RAW_INPUT = 1'b1;
        for (int e = 1; e <= 9; e++) begin
            step();
            exp = (e >= 6);
            n_cmp++;
            if (DEBOUNCED !== exp) begin
                n_bad++;
                $display("FAIL clean_rise edge %0d: got %b want %b", e, DEBOUNCED, exp);
            end
        end
        n_cmp++;
        if (GLITCH_COUNT !== 3'd0) begin
            n_bad++;
            $display("FAIL clean_rise_glitch: got %0d want 0", GLITCH_COUNT);
        end
    endtask

    // High for 2 captures: FSM sees 1 at edges 3,4, aborts at edge 5
    task automatic test_glitch();
        logic [2:0] exp_g;
        do_reset();
        for (int e = 1; e <= 10; e++) begin
            RAW_INPUT = (e <= 2);
            step();
            exp_g = (e >= 5) ? 3'd1 : 3'd0;
            n_cmp++;
            if (DEBOUNCED !== 1'b0) begin
                n_bad++;
                $display("FAIL glitch_deb edge %0d: got %b want 0", e, DEBOUNCED);
            end
            n_cmp++;
            if (GLITCH_COUNT !== exp_g) begin
                n_bad++;
                $display("FAIL glitch_cnt edge %0d: got %0d want %0d", e, GLITCH_COUNT, exp_g);
            end
        end
    endtask

    // 3-cycle pulse aborts at edge 6; 4-cycle pulse commits at 6, falls at 10
    task automatic test_borderline();
        logic       exp;
        logic [2:0] exp_g;
        do_reset();
        for (int e = 1; e <= 12; e++) begin
            RAW_INPUT = (e <= 3);
            step();
            exp_g = (e >= 6) ? 3'd1 : 3'd0;
            n_cmp++;
            if (DEBOUNCED !== 1'b0) begin
                n_bad++;
                $display("FAIL border3_deb edge %0d: got %b want 0", e, DEBOUNCED);
            end
            n_cmp++;
            if (GLITCH_COUNT !== exp_g) begin
                n_bad++;
                $display("FAIL border3_cnt edge %0d: got %0d want %0d", e, GLITCH_COUNT, exp_g);
            end
        end
        do_reset();
        for (int e = 1; e <= 14; e++) begin
            RAW_INPUT = (e <= 4);
            step();
            exp = (e >= 6) && (e <= 9);
            n_cmp++;
            if (DEBOUNCED !== exp) begin
                n_bad++;
                $display("FAIL border4_deb edge %0d: got %b want %b", e, DEBOUNCED, exp);
            end
        end
        n_cmp++;
        if (GLITCH_COUNT !== 3'd0) begin
            n_bad++;
            $display("FAIL border4_cnt: got %0d want 0", GLITCH_COUNT);
        end
    endtask

    // Nine glitches saturate at 7; clear on the tenth abort edge yields 0
    task automatic test_saturation_clear();
        logic [2:0] exp_g;
        do_reset();
        for (int g = 1; g <= 9; g++) begin
            for (int e = 1; e <= 6; e++) begin
                RAW_INPUT = (e <= 2);
                step();
            end
            exp_g = (g >= 7) ? 3'd7 : 3'(g);
            n_cmp++;
            if (GLITCH_COUNT !== exp_g) begin
                n_bad++;
                $display("FAIL sat_cnt glitch %0d: got %0d want %0d", g, GLITCH_COUNT, exp_g);
            end
        end
        for (int e = 1; e <= 6; e++) begin
            RAW_INPUT    = (e <= 2);
            GLITCH_CLEAR = (e == 5);
            step();
            if (e == 4) begin
                n_cmp++;
                if (GLITCH_COUNT !== 3'd7) begin
                    n_bad++;
                    $display("FAIL sat_pre_clear: got %0d want 7", GLITCH_COUNT);
                end
            end
            if (e >= 5) begin
                n_cmp++;
                if (GLITCH_COUNT !== 3'd0) begin
                    n_bad++;
                    $display("FAIL clear_vs_abort edge %0d: got %0d want 0", e, GLITCH_COUNT);
                end
            end
        end
        GLITCH_CLEAR = 1'b0;
        n_cmp++;
        if (DEBOUNCED !== 1'b0) begin
            n_bad++;
            $display("FAIL sat_deb: got %b want 0", DEBOUNCED);
        end
    endtask

    // Reset during CHECK (counter=2 after edge 4); then rise 5 edges after
    // the first post-reset capture edge
    task automatic test_mid_reset();
        logic exp;
        do_reset();
        RAW_INPUT = 1'b1;
        for (int e = 1; e <= 4; e++) begin
            step();
        end
        RESET = 1'b1;
        step();
        n_cmp++;
        if (DEBOUNCED !== 1'b0) begin
            n_bad++;
            $display("FAIL mid_reset_deb: got %b want 0", DEBOUNCED);
        end
        n_cmp++;
        if (GLITCH_COUNT !== 3'd0) begin
            n_bad++;
            $display("FAIL mid_reset_cnt: got %0d want 0", GLITCH_COUNT);
        end
        RESET = 1'b0;
        for (int e = 1; e <= 8; e++) begin
            step();
            exp = (e >= 6);
            n_cmp++;
            if (DEBOUNCED !== exp) begin
                n_bad++;
                $display("FAIL mid_reset_rise edge %0d: got %b want %b", e, DEBOUNCED, exp);
            end
            n_cmp++;
            if (GLITCH_COUNT !== 3'd0) begin
                n_bad++;
                $display("FAIL mid_reset_glitch edge %0d: got %0d want 0", e, GLITCH_COUNT);
            end
        end
    endtask

    // Toggle for 20 captures (1,0,...,0), then hold 1 from capture 21:
    // ten one-cycle pulses abort, final level reaches sync after edge 22,
    // commit at edge 26
    task automatic test_back_to_back_bounce();
        logic exp;
        do_reset();
        for (int e = 1; e <= 32; e++) begin
            RAW_INPUT = (e <= 20) ? ((e % 2) == 1) : 1'b1;
            step();
            exp = (e >= 26);
            n_cmp++;
            if (DEBOUNCED !== exp) begin
                n_bad++;
                $display("FAIL bounce_deb edge %0d: got %b want %b", e, DEBOUNCED, exp);
            end
        end
        n_cmp++;
        if (GLITCH_COUNT !== 3'd7) begin
            n_bad++;
            $display("FAIL bounce_cnt: got %0d want 7", GLITCH_COUNT);
        end
    endtask

    initial begin
        n_cmp        = 0;
        n_bad        = 0;
        RESET        = 1'b1;
        RAW_INPUT    = 1'b0;
        GLITCH_CLEAR = 1'b0;
        test_reset();
        test_clean_rise();
        test_glitch();
        test_borderline();
        test_saturation_clear();
        test_mid_reset();
        test_back_to_back_bounce();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
